// File: rtl/keypad_scan_fifo_pkg.sv
// Shared types and constants for the keypad scanner and its key-code queue.
package keypad_scan_fifo_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam int KEYCODE_W = 4;

    // filtered_out bit positions
    localparam int VALID  = 31;
    localparam int OVF    = 30;
    localparam int CNT_HI = 29;
    localparam int CNT_LO = 27;

    // Index of the lowest active-low column; 0 when none is low
    function automatic logic [1:0] lowest_low_col(input logic [3:0] c);
        lowest_low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) lowest_low_col = 2'(i);
        end
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// Small key-code queue with occupancy count and sticky overflow flag.
// Handshake: push and pop are single-cycle strobes sampled on the rising
// edge. A pop is accepted only when the queue is not empty; a push is
// accepted when there is room or when an accepted pop frees a slot in the
// same cycle. A push that finds the queue full with no accepted pop is
// dropped and sets overflow; any accepted pop clears overflow unless a
// drop happens in that same cycle.
module kp_fifo
    import keypad_scan_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = KEYCODE_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 data,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_acc;
    logic          push_acc;
    logic          push_drop;

    // Pointers wrap explicitly at DEPTH-1
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        ptr_inc = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_acc   = pop && !empty;
    assign push_acc  = push && (!full || pop_acc);
    assign push_drop = push && full && !pop_acc;
    assign head      = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= data;
    end

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_acc && !pop_acc)      count <= count + 1'b1;
            else if (pop_acc && !push_acc) count <= count - 1'b1;
            if (push_drop)    overflow <= 1'b1;
            else if (pop_acc) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad scanner with press/release debouncing feeding a key-code queue.
// Rows are driven one at a time; columns are sampled once per row dwell.
module keypad_scan_fifo
    import keypad_scan_fifo_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    input  logic        pop,
    output logic [31:0] filtered_out,
    output kp_state_e   dbg_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_SCANS - 1);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    logic [3:0]           cols_s1;
    logic [3:0]           cols_s2;
    logic [DW-1:0]        dwell;
    logic                 sample;
    logic                 all_high;
    kp_state_e            state_q, state_nx;
    logic [1:0]           row_q, row_nx;
    logic [MW-1:0]        match_q, match_nx;
    logic [3:0]           pat_q, pat_nx;
    logic                 push_q, push_nx;
    logic [KEYCODE_W-1:0] code_q, code_nx;

    logic [KEYCODE_W-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCW-1:0]       fifo_count;
    logic                 fifo_ovf;
    logic [31:0]          status_word;

    assign sample    = (dwell == DWELL_LAST);
    assign all_high  = (cols_s2 == 4'hF);
    assign rows      = ~(4'b0001 << row_q);
    assign dbg_state = state_q;

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cols_s1 <= 4'hF;
            cols_s2 <= 4'hF;
        end else begin
            cols_s1 <= cols;
            cols_s2 <= cols_s1;
        end
    end

    // Row dwell counter; the last count of each dwell is the sample point
    always_ff @(posedge clk) begin
        if (reset)       dwell <= '0;
        else if (sample) dwell <= '0;
        else             dwell <= dwell + 1'b1;
    end

    // Scanner state, row, match count, latched pattern and push request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SCAN;
            row_q   <= 2'd0;
            match_q <= '0;
            pat_q   <= 4'hF;
            push_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_nx;
            row_q   <= row_nx;
            match_q <= match_nx;
            pat_q   <= pat_nx;
            push_q  <= push_nx;
            code_q  <= code_nx;
        end
    end

    // Scan/debounce decisions, taken only at the sample point
    always_comb begin
        state_nx = state_q;
        row_nx   = row_q;
        match_nx = match_q;
        pat_nx   = pat_q;
        push_nx  = 1'b0;
        code_nx  = code_q;
        if (sample) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (all_high) begin
                        row_nx = row_q + 2'd1;
                    end else begin
                        pat_nx   = cols_s2;
                        match_nx = MATCH_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            push_nx  = 1'b1;
                            code_nx  = {row_q, lowest_low_col(cols_s2)};
                            state_nx = ST_HELD;
                        end else begin
                            state_nx = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (cols_s2 == pat_q) begin
                        if (match_q == MATCH_LAST) begin
                            push_nx  = 1'b1;
                            code_nx  = {row_q, lowest_low_col(pat_q)};
                            state_nx = ST_HELD;
                        end else begin
                            match_nx = match_q + 1'b1;
                        end
                    end else begin
                        row_nx   = row_q + 2'd1;
                        match_nx = '0;
                        state_nx = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (all_high) begin
                        match_nx = MATCH_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            row_nx   = row_q + 2'd1;
                            state_nx = ST_SCAN;
                        end else begin
                            state_nx = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (all_high) begin
                        if (match_q == MATCH_LAST) begin
                            row_nx   = row_q + 2'd1;
                            match_nx = '0;
                            state_nx = ST_SCAN;
                        end else begin
                            match_nx = match_q + 1'b1;
                        end
                    end else begin
                        state_nx = ST_HELD;
                    end
                end
                default: state_nx = ST_SCAN;
            endcase
        end
    end

    kp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEYCODE_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_q),
        .pop      (pop),
        .data     (code_q),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    // Assemble the status word from the queue state
    always_comb begin
        status_word                     = '0;
        status_word[VALID]              = !fifo_empty;
        status_word[OVF]                = fifo_ovf;
        status_word[CNT_HI:CNT_LO]      = 3'(fifo_count);
        status_word[KEYCODE_W-1:0]      = fifo_head;
    end

    // Registered status word read by the controller
    always_ff @(posedge clk) begin
        if (reset) filtered_out <= 32'h0;
        else       filtered_out <= status_word;
    end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: keypad model, per-sample reference model,
// status-word scoreboard with a separate monitor process.
`timescale 1ns/1ps
module tb_keypad_scan_fifo;
    import keypad_scan_fifo_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int DEPTH    = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        pop   = 1'b0;
    logic [31:0] filtered_out;
    kp_state_e   dbg_state;

    always #5 clk = ~clk;

    keypad_scan_fifo #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cols         (cols),
        .rows         (rows),
        .pop          (pop),
        .filtered_out (filtered_out),
        .dbg_state    (dbg_state)
    );

    // ---------------- keypad model ----------------
    // keys[r*4+c] = 1 means the key at row r, column c is pressed
    logic [15:0] keys = 16'h0;

    function automatic logic [3:0] row_cols(input logic [15:0] k, input int row);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 4; i++) if (k[row*4+i]) c[i] = 1'b0;
        return c;
    endfunction

    always_comb begin
        cols = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (!rows[rr]) cols = cols & row_cols(keys, rr);
        end
    end

    // ---------------- counters and scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'h0;
    logic [31:0] seen     = 32'h0;
    logic [31:0] mon_exp;
    logic [3:0]  exp_rows;
    bit          mon_on   = 1'b0;
    int          age      = 0;

    // ---------------- reference model ----------------
    // states: 0 idle scan, 1 confirming press, 2 held, 3 confirming release
    int          m_state = 0;
    int          m_r     = 0;
    int          m_cnt   = 0;
    int          m_phase = 0;
    logic [3:0]  m_pat   = 4'hF;
    bit          m_pend  = 1'b0;
    logic [3:0]  m_code  = 4'h0;
    logic [3:0]  m_fifo[$];
    bit          m_ovf   = 1'b0;

    function automatic int low_col(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = 32'h0;
        if (m_fifo.size() > 0) begin
            w[31]  = 1'b1;
            w[3:0] = m_fifo[0];
        end
        w[30]    = m_ovf;
        w[29:27] = 3'(m_fifo.size());
        return w;
    endfunction

    task automatic note_word();
        logic [31:0] w;
        w = model_word();
        if (w !== last_exp) begin
            exp_q.push_back(w);
            last_exp = w;
        end
    endtask

    task automatic fifo_step(input bit do_push, input logic [3:0] code, input bit do_pop);
        int sz;
        bit pop_ok;
        bit drop;
        sz     = m_fifo.size();
        pop_ok = do_pop && (sz > 0);
        drop   = do_push && (sz == DEPTH) && !pop_ok;
        if (pop_ok) m_fifo.delete(0);
        if (do_push && !drop) m_fifo.push_back(code);
        if (drop) m_ovf = 1'b1;
        else if (pop_ok) m_ovf = 1'b0;
        note_word();
    endtask

    task automatic confirm();
        m_pend  = 1'b1;
        m_code  = 4'(m_r * 4 + low_col(m_pat));
        m_state = 2;
    endtask

    task automatic fsm_step(input logic [3:0] s);
        bit hi;
        hi = (s == 4'hF);
        case (m_state)
            0: if (hi) m_r = (m_r + 1) % 4;
               else begin
                   m_pat = s; m_cnt = 1;
                   if (m_cnt >= DEB) confirm(); else m_state = 1;
               end
            1: if (s == m_pat) begin
                   m_cnt++;
                   if (m_cnt >= DEB) confirm();
               end else begin
                   m_r = (m_r + 1) % 4; m_state = 0;
               end
            2: if (hi) begin
                   m_cnt = 1;
                   if (m_cnt >= DEB) begin m_r = (m_r + 1) % 4; m_state = 0; end
                   else m_state = 3;
               end
            default: if (hi) begin
                   m_cnt++;
                   if (m_cnt >= DEB) begin m_r = (m_r + 1) % 4; m_state = 0; end
               end else m_state = 2;
        endcase
    endtask

    task automatic model_edge();
        fifo_step(m_pend, m_code, pop);
        m_pend = 1'b0;
        if (m_phase == SCAN_DIV - 1) fsm_step(row_cols(keys, m_r));
        m_phase = (m_phase + 1) % SCAN_DIV;
    endtask

    task automatic model_reset();
        m_state = 0; m_r = 0; m_cnt = 0; m_phase = 0;
        m_pat = 4'hF; m_pend = 1'b0; m_ovf = 1'b0;
        m_fifo.delete();
        note_word();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            if (filtered_out !== seen) begin
                seen = filtered_out;
                age  = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=no change", filtered_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (filtered_out !== mon_exp) begin
                        errors++;
                        $display("FAIL status_word actual=%h required=%h", filtered_out, mon_exp);
                    end
                end
            end else if (exp_q.size() > 0) begin
                age++;
                if (age > 6) begin
                    checks++;
                    errors++;
                    $display("FAIL word_timeout actual=%h required=%h", filtered_out, exp_q[0]);
                    exp_q.delete(0);
                    age = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: rows checked before each sample edge, model advanced after it
    task automatic tick();
        if (m_phase == SCAN_DIV - 1 && !reset) begin
            exp_rows = ~(4'b0001 << m_r);
            check("rows_scan", {28'h0, rows}, {28'h0, exp_rows});
        end
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
    endtask

    // One row dwell with a fixed key mask; optional pop at a given phase,
    // or on the cycle a push lands
    task automatic slot(input logic [15:0] k, input int pop_phase, input bit pop_on_push);
        keys = k;
        for (int i = 0; i < SCAN_DIV; i++) begin
            pop = (i == pop_phase) || (pop_on_push && m_pend);
            tick();
        end
        pop = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pop   = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_row(input int row);
        int n;
        n = 0;
        while (!(m_r == row && m_state == 0) && n < 12) begin
            slot(16'h0, 9, 1'b0);
            n++;
        end
        if (n == 12) begin
            checks++;
            errors++;
            $display("FAIL wait_row actual=%0d required=%0d", m_r, row);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_fifo.size() > 0 && n < 10) begin
            slot(16'h0, 2, 1'b0);
            n++;
        end
        slot(16'h0, 9, 1'b0);
    endtask

    task automatic press(input int idx, input int hold, input int rel);
        logic [15:0] k;
        k = 16'h0;
        k[idx] = 1'b1;
        repeat (hold) slot(k, 9, 1'b0);
        repeat (rel) slot(16'h0, 9, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] k;
        logic [15:0] kk;
        int          n;

        do_reset(3);
        mon_on = 1'b1;
        check("reset_rows", {28'h0, rows}, 32'hE);
        check("reset_word", filtered_out, 32'h0);
        check("reset_state", 32'(dbg_state), 32'(ST_SCAN));

        // single press on row 2, column 1, held 5 samples
        wait_row(2);
        repeat (5) slot(16'h0200, 9, 1'b0);
        repeat (6) slot(16'h0000, 9, 1'b0);
        check("single_press_word", filtered_out, 32'h8800_0009);
        drain();
        check("drained_word", filtered_out, 32'h0);

        // bounce: two detecting samples then release, no push
        wait_row(2);
        repeat (2) slot(16'h0200, 9, 1'b0);
        slot(16'h0000, 9, 1'b0);
        check("bounce_rows", {28'h0, rows}, 32'h7);
        check("bounce_word", filtered_out, 32'h0);

        // five distinct presses into a 4-deep queue
        press(1, 8, 6);
        press(6, 8, 6);
        press(11, 8, 6);
        press(12, 8, 6);
        press(3, 8, 6);
        check("overflow_status", {27'h0, filtered_out[31:27]}, 32'b11100);
        check("overflow_head", {28'h0, filtered_out[3:0]}, 32'h1);
        slot(16'h0, 1, 1'b0);
        slot(16'h0, 9, 1'b0);
        check("after_pop_status", {27'h0, filtered_out[31:27]}, 32'b10011);
        check("after_pop_head", {28'h0, filtered_out[3:0]}, 32'h6);

        // pops on an empty queue are ignored
        drain();
        repeat (3) slot(16'h0, 1, 1'b0);
        check("empty_pop_word", filtered_out, 32'h0);

        // push into a full queue coincident with a pop
        press(5, 8, 6);
        press(10, 8, 6);
        press(15, 8, 6);
        press(0, 8, 6);
        k = 16'h0;
        k[7] = 1'b1;
        repeat (8) slot(k, 9, 1'b1);
        repeat (6) slot(16'h0, 9, 1'b0);
        check("push_pop_full_status", {27'h0, filtered_out[31:27]}, 32'b10100);
        check("push_pop_full_head", {28'h0, filtered_out[3:0]}, 32'hA);

        // reset while a key on row 1 is held
        drain();
        n = 0;
        while (m_state != 2 && n < 10) begin
            slot(k, 9, 1'b0);
            n++;
        end
        repeat (2) slot(k, 9, 1'b0);
        tick();
        do_reset(1);
        check("held_reset_rows", {28'h0, rows}, 32'hE);
        check("held_reset_word", filtered_out, 32'h0);
        repeat (8) slot(k, 9, 1'b0);
        repeat (6) slot(16'h0, 9, 1'b0);
        check("redetect_word", filtered_out, 32'h8800_0007);

        // long hold on row 3 column 2, then glitchy release
        drain();
        k = 16'h0;
        k[14] = 1'b1;
        repeat (24) slot(k, 9, 1'b0);
        kk = 16'h0;
        kk[12] = 1'b1;
        slot(16'h0, 9, 1'b0);
        slot(kk, 9, 1'b0);
        slot(16'h0, 9, 1'b0);
        slot(16'h0, 9, 1'b0);
        check("release_frozen_rows", {28'h0, rows}, 32'h7);
        slot(16'h0, 9, 1'b0);
        check("release_advance_rows", {28'h0, rows}, 32'hE);
        check("long_hold_word", filtered_out, 32'h8800_000E);

        // randomized presses, bounces and pops
        for (int it = 0; it < 30; it++) begin
            k = 16'h0;
            k[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) k[$urandom_range(0, 15)] = 1'b1;
            repeat ($urandom_range(1, 10)) begin
                kk = ($urandom_range(0, 5) == 0) ? 16'h0 : k;
                slot(kk, $urandom_range(0, 11), 1'b0);
            end
            repeat ($urandom_range(1, 6)) slot(16'h0, $urandom_range(0, 11), 1'b0);
        end

        drain();
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
